key_switch_io: RTL and testbench

//   Memory-mapped input peripheral feeding the processor's data bus from the board KEY[3:0]
//   and SW[9:0] pins.
//   - Synchronises and debounces the raw pins.
//   - Latches change events into ready/overrun status bits.
//   - Raises a level interrupt request.
//   - Sits between the board pins and the processor's load/store path, beside the HEX/LEDR output devices.

---
 rtl/key_switch_io.sv | 147 ++++++++++++++
 tb/tb_key_switch_io.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_switch_io.sv
// Memory-mapped KEY/SW input device: synchronise, debounce, latch change events, raise a level interrupt.
// Optional debouncer enabled by defining KEY_SWITCH_DEBOUNCE_EN; otherwise the synchronised value is taken directly.

module key_switch_chan #(
  parameter int unsigned W               = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd10000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pin,
  input  logic         data_rd,
  input  logic         ctrl_wr,
  input  logic         ovr_wbit,
  input  logic         ie_wbit,
  output logic [W-1:0] deb,
  output logic         rdy,
  output logic         ovr,
  output logic         ie
);
  logic [W-1:0] s1, sync;
  logic         evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= pin;
      sync <= s1;
    end
  end

`ifdef KEY_SWITCH_DEBOUNCE_EN
  logic [W-1:0] prev;
  logic [15:0]  cnt;

  // cnt counts stable cycles after the first one, so the value is accepted on
  // its DEBOUNCE_CYCLES-th consecutive stable cycle.
  assign evt = (sync != deb) && (sync == prev) && (cnt == DEBOUNCE_CYCLES - 16'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      cnt  <= '0;
      deb  <= '0;
    end else begin
      prev <= sync;
      if (sync == deb || sync != prev || evt) cnt <= '0;
      else                                    cnt <= cnt + 16'd1;
      if (evt) deb <= sync;
    end
  end
`else
  logic [15:0] unused_cycles;
  assign unused_cycles = DEBOUNCE_CYCLES;
  assign evt = (sync != deb);

  always_ff @(posedge clk) begin
    if (reset) deb <= '0;
    else       deb <= sync;
  end
`endif

  // A new event outranks a simultaneous DATA read; OVR set outranks a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy <= 1'b0;
      ovr <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (evt)          rdy <= 1'b1;
      else if (data_rd) rdy <= 1'b0;
      if (evt && rdy && !data_rd) ovr <= 1'b1;
      else if (ctrl_wr && !ovr_wbit) ovr <= 1'b0;
      if (ctrl_wr) ie <= ie_wbit;
    end
  end
endmodule

module key_switch_io #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] KEY_BASE        = 32'hF0000010,
  parameter logic [DBITS-1:0] SW_BASE         = 32'hF0000014,
  parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             we,
  input  logic             re,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  input  logic [3:0]       key_raw,
  input  logic [9:0]       sw_raw,
  output logic             intr
);
  localparam logic [DBITS-1:0] KCTRL_ADDR = KEY_BASE + DBITS'(4);
  localparam logic [DBITS-1:0] SCTRL_ADDR = SW_BASE + DBITS'(4);

  logic       m_kd, m_kc, m_sd, m_sc;
  logic [3:0] kdeb;
  logic [9:0] sdeb;
  logic       krdy, kovr, kie, srdy, sovr, sie;
  logic       unused_bits;

  assign m_kd = (addr[DBITS-1:2] == KEY_BASE[DBITS-1:2]);
  assign m_kc = (addr[DBITS-1:2] == KCTRL_ADDR[DBITS-1:2]);
  assign m_sd = (addr[DBITS-1:2] == SW_BASE[DBITS-1:2]);
  assign m_sc = (addr[DBITS-1:2] == SCTRL_ADDR[DBITS-1:2]);
  assign sel  = m_kd | m_kc | m_sd | m_sc;

  assign unused_bits = ^{addr[1:0], wdata[DBITS-1:9], wdata[7:3], wdata[1:0]};

  key_switch_chan #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk(clk), .reset(reset), .pin(~key_raw),
    .data_rd(re && m_kd), .ctrl_wr(we && m_kc), .ovr_wbit(wdata[2]), .ie_wbit(wdata[8]),
    .deb(kdeb), .rdy(krdy), .ovr(kovr), .ie(kie)
  );

  key_switch_chan #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clk(clk), .reset(reset), .pin(sw_raw),
    .data_rd(re && m_sd), .ctrl_wr(we && m_sc), .ovr_wbit(wdata[2]), .ie_wbit(wdata[8]),
    .deb(sdeb), .rdy(srdy), .ovr(sovr), .ie(sie)
  );

  // The default bases put KCTRL and SDATA on the same word: loads return the
  // DATA register, stores reach the CTRL register (DATA stores are ignored anyway).
  always_comb begin
    rdata = '0;
    if (m_kd) begin
      rdata[3:0] = kdeb;
    end else if (m_sd) begin
      rdata[9:0] = sdeb;
    end else if (m_kc) begin
      rdata[0] = krdy;
      rdata[2] = kovr;
      rdata[8] = kie;
    end else if (m_sc) begin
      rdata[0] = srdy;
      rdata[2] = sovr;
      rdata[8] = sie;
    end
  end

  assign intr = (krdy & kie) | (srdy & sie);
endmodule

// File: tb/tb_key_switch_io.sv
// Self-checking bench for key_switch_io: directed table, hand sequences and random traffic
// checked against a history-window reference model.

module tb_key_switch_io;
  localparam logic [31:0] KB = 32'hF0000010;
  localparam logic [31:0] KC = 32'hF0000014;
  localparam logic [31:0] SB = 32'hF0000020;
  localparam logic [31:0] SC = 32'hF0000024;
`ifdef KEY_SWITCH_DEBOUNCE_EN
  localparam int W = 4;
`else
  localparam int W = 1;
`endif
  localparam int LAT = 2 + W;

  logic        clk = 1'b0;
  logic        reset, we, re, sel, intr;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  key_raw;
  logic [9:0]  sw_raw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_switch_io #(.DBITS(32), .KEY_BASE(KB), .SW_BASE(SB), .DEBOUNCE_CYCLES(16'd4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .sel(sel), .key_raw(key_raw), .sw_raw(sw_raw), .intr(intr)
  );

  // Reference model: a value is accepted once the last W synchronised samples agree and differ from deb.
  logic [3:0] mk1, mk2, mkdeb;
  logic [9:0] ms1, ms2, msdeb;
  logic [3:0] kh[4];
  logic [9:0] sh[4];
  logic       mkrdy, mkovr, mkie, msrdy, msovr, msie;

  function automatic logic [31:0] wa(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (wa(a) == KB)      v = {28'd0, mkdeb};
    else if (wa(a) == KC) v = {23'd0, mkie, 5'd0, mkovr, 1'b0, mkrdy};
    else if (wa(a) == SB) v = {22'd0, msdeb};
    else if (wa(a) == SC) v = {23'd0, msie, 5'd0, msovr, 1'b0, msrdy};
    return v;
  endfunction

  task automatic m_edge();
    logic kev, sev, krd, srd, kcw, scw;
    if (reset) begin
      mk1 = '0; mk2 = '0; mkdeb = '0; ms1 = '0; ms2 = '0; msdeb = '0;
      for (int i = 0; i < 4; i++) begin kh[i] = '0; sh[i] = '0; end
      mkrdy = 0; mkovr = 0; mkie = 0; msrdy = 0; msovr = 0; msie = 0;
    end else begin
      for (int i = W - 1; i > 0; i--) begin kh[i] = kh[i-1]; sh[i] = sh[i-1]; end
      kh[0] = mk2;
      sh[0] = ms2;
      kev = (kh[0] != mkdeb);
      sev = (sh[0] != msdeb);
      for (int i = 1; i < W; i++) begin
        if (kh[i] != kh[0]) kev = 0;
        if (sh[i] != sh[0]) sev = 0;
      end
      krd = re && (wa(addr) == KB);
      srd = re && (wa(addr) == SB);
      kcw = we && (wa(addr) == KC);
      scw = we && (wa(addr) == SC);
      if (kev && mkrdy && !krd) mkovr = 1; else if (kcw && !wdata[2]) mkovr = 0;
      if (sev && msrdy && !srd) msovr = 1; else if (scw && !wdata[2]) msovr = 0;
      mkrdy = kev ? 1'b1 : (krd ? 1'b0 : mkrdy);
      msrdy = sev ? 1'b1 : (srd ? 1'b0 : msrdy);
      if (kcw) mkie = wdata[8];
      if (scw) msie = wdata[8];
      if (kev) mkdeb = kh[0];
      if (sev) msdeb = sh[0];
      mk2 = mk1; mk1 = ~key_raw;
      ms2 = ms1; ms1 = sw_raw;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    check("model_rdata", rdata, m_read(addr));
    check("model_sel", {31'd0, sel}, {31'd0, (wa(addr) == KB) || (wa(addr) == KC) || (wa(addr) == SB) || (wa(addr) == SC)});
    check("model_intr", {31'd0, intr}, {31'd0, (mkrdy & mkie) | (msrdy & msie)});
  endtask

  task automatic drive(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d);
    addr = a; re = r; we = w; wdata = d;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 1'b0, 1'b0, '0);
    #1;
    check(name, rdata, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{addr: KB,            re: 1, we: 0, wdata: 32'h0,        exp_rdata: 32'h0,   exp_sel: 1};
    tbl[1]  = '{addr: KC,            re: 1, we: 0, wdata: 32'h0,        exp_rdata: 32'h0,   exp_sel: 1};
    tbl[2]  = '{addr: SB,            re: 1, we: 0, wdata: 32'h0,        exp_rdata: 32'h0,   exp_sel: 1};
    tbl[3]  = '{addr: SC,            re: 1, we: 0, wdata: 32'h0,        exp_rdata: 32'h0,   exp_sel: 1};
    tbl[4]  = '{addr: KC,            re: 0, we: 1, wdata: 32'h104,      exp_rdata: 32'h100, exp_sel: 1};
    tbl[5]  = '{addr: KB + 32'd7,    re: 0, we: 0, wdata: 32'h0,        exp_rdata: 32'h100, exp_sel: 1};
    tbl[6]  = '{addr: KB,            re: 0, we: 1, wdata: 32'hFFFFFFFF, exp_rdata: 32'h0,   exp_sel: 1};
    tbl[7]  = '{addr: SC,            re: 0, we: 1, wdata: 32'hFFFFFEFF, exp_rdata: 32'h0,   exp_sel: 1};
    tbl[8]  = '{addr: 32'hF0000018,  re: 1, we: 1, wdata: 32'hFFFFFFFF, exp_rdata: 32'h0,   exp_sel: 0};
    tbl[9]  = '{addr: 32'h0,         re: 1, we: 0, wdata: 32'h0,        exp_rdata: 32'h0,   exp_sel: 0};
    tbl[10] = '{addr: KC,            re: 0, we: 1, wdata: 32'h0,        exp_rdata: 32'h0,   exp_sel: 1};

    reset = 1; key_raw = 4'hF; sw_raw = '0;
    drive(32'h0, 0, 0, 32'h0);
    tick(); tick();
    reset = 0;

    // Reset state
    peek("reset_kdata", KB, 32'h0);
    peek("reset_kctrl", KC, 32'h0);
    peek("reset_sdata", SB, 32'h0);
    peek("reset_sctrl", SC, 32'h0);
    check("reset_intr", {31'd0, intr}, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    // Register access table
    for (int unsigned i = 0; i < 11; i++) begin
      drive(tbl[i].addr, tbl[i].re, tbl[i].we, tbl[i].wdata);
      tick();
      drive(tbl[i].addr, 1'b0, 1'b0, '0);
      #1;
      check($sformatf("table%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("table%0d_sel", i), {31'd0, sel}, {31'd0, tbl[i].exp_sel});
    end

    // Key press latency and read-clears-RDY
    key_raw = 4'hE;
    drive(KB, 0, 0, '0);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check($sformatf("kdata_latency_%0d", k), rdata, (k >= LAT) ? 32'h1 : 32'h0);
    end
    peek("kctrl_rdy", KC, 32'h1);
    drive(KB, 1, 0, '0);
    tick();
    peek("kctrl_after_read", KC, 32'h0);

    // Switch bounce
    drive(SB, 0, 0, '0);
    sw_raw = 10'h001; tick();
    sw_raw = 10'h000; tick();
    sw_raw = 10'h001; tick();
    sw_raw = 10'h000;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
`ifdef KEY_SWITCH_DEBOUNCE_EN
      check("bounce_sdata", rdata, 32'h0);
`endif
    end
`ifdef KEY_SWITCH_DEBOUNCE_EN
    peek("bounce_sctrl", SC, 32'h0);
`endif
    drive(SB, 1, 0, '0); tick();
    drive(SC, 0, 1, 32'h0); tick();

    // Switch event with interrupt enabled
    drive(SC, 0, 1, 32'h100); tick();
    sw_raw = 10'h3FF;
    drive(SB, 0, 0, '0);
    for (int k = 0; k < LAT; k++) tick();
    check("sw_sdata", rdata, 32'h3FF);
    check("sw_intr", {31'd0, intr}, 32'h1);
    peek("sw_sctrl", SC, 32'h101);
    drive(SB, 1, 0, '0); tick();
    check("sw_intr_cleared", {31'd0, intr}, 32'h0);
    drive(SC, 0, 1, 32'h0); tick();

    // Overrun: two key changes, then clear OVR
    drive(KC, 0, 0, '0);
    key_raw = 4'hC;
    for (int k = 0; k < LAT; k++) tick();
    key_raw = 4'h8;
    for (int k = 0; k < LAT; k++) tick();
    peek("kctrl_overrun", KC, 32'h5);
    drive(KC, 0, 1, 32'h0); tick();
    peek("kctrl_ovr_cleared", KC, 32'h1);

    // Reset in the middle of a debounce count
    key_raw = 4'hE;
    drive(KB, 0, 0, '0);
    for (int k = 0; k < 5; k++) tick();
    reset = 1; tick(); reset = 0;
    peek("midreset_kdata", KB, 32'h0);
    peek("midreset_kctrl", KC, 32'h0);
    peek("midreset_sdata", SB, 32'h0);
    peek("midreset_sctrl", SC, 32'h0);
    check("midreset_intr", {31'd0, intr}, 32'h0);
    drive(KB, 0, 0, '0);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check($sformatf("fresh_kdata_%0d", k), rdata, (k >= LAT) ? 32'h1 : 32'h0);
    end

    // Random traffic against the model
    for (int unsigned n = 0; n < 3000; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0: a = KB;
        1: a = KC;
        2: a = SB;
        3: a = SC;
        default: a = $urandom;
      endcase
      a = a | {30'd0, 2'($urandom_range(0, 3))};
      drive(a, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 7) == 0) key_raw = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sw_raw = 10'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
